// File: rtl/two_write_one_read_reg_file.sv
// Two-write, one-read register file: 32 entries of DATA_WIDTH bits with a
// per-entry "written" bitmap. Reads return data one cycle later, and only
// for entries written since the last reset. Requests that touch the same
// entry from two sides in one cycle are rejected and flagged via collision.
// Optional macro WRITE_FORWARD_EN: a read matching an enabled write address
// is forwarded from that write's data instead of being treated as a conflict.
module two_write_one_read_reg_file #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [4:0]            wad1,
    input  logic                  wen1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [4:0]            wad2,
    input  logic                  wen2,
    input  logic [4:0]            rad1,
    input  logic                  ren1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout_valid,
    output logic                  collision
);

    localparam int DEPTH = 32;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      written_q, written_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  collision_q, collision_d;

    logic conflict_ww;
    logic conflict;

    // Two writes to the same entry are always ambiguous.
    assign conflict_ww = wen1 & wen2 & (wad1 == wad2);

`ifdef WRITE_FORWARD_EN
    logic fwd1;
    logic fwd2;

    // Read hits an in-flight write: serve it from that write's data.
    assign fwd1     = ren1 & wen1 & (rad1 == wad1);
    assign fwd2     = ren1 & wen2 & (rad1 == wad2);
    assign conflict = conflict_ww;
`else
    logic conflict_r1;
    logic conflict_r2;

    // Without forwarding, reading an entry being written is also ambiguous.
    assign conflict_r1 = wen1 & ren1 & (rad1 == wad1);
    assign conflict_r2 = wen2 & ren1 & (rad1 == wad2);
    assign conflict    = conflict_ww | conflict_r1 | conflict_r2;
`endif

    // Next-state: a conflicting request changes nothing but the collision flag.
    always_comb begin
        mem_d        = mem_q;
        written_d    = written_q;
        dout1_d      = dout1_q;
        dout_valid_d = 1'b0;
        collision_d  = 1'b0;

        if (conflict) begin
            collision_d = 1'b1;
        end else begin
            if (wen1) begin
                mem_d[wad1]     = din1;
                written_d[wad1] = 1'b1;
            end
            if (wen2) begin
                mem_d[wad2]     = din2;
                written_d[wad2] = 1'b1;
            end
            if (ren1) begin
`ifdef WRITE_FORWARD_EN
                if (fwd1) begin
                    dout1_d      = din1;
                    dout_valid_d = 1'b1;
                end else if (fwd2) begin
                    dout1_d      = din2;
                    dout_valid_d = 1'b1;
                end else if (written_q[rad1]) begin
                    dout1_d      = mem_q[rad1];
                    dout_valid_d = 1'b1;
                end
`else
                if (written_q[rad1]) begin
                    dout1_d      = mem_q[rad1];
                    dout_valid_d = 1'b1;
                end
`endif
            end
        end
    end

    // Control/output state; reset clears the bitmap so old contents are unreadable.
    always_ff @(posedge clk) begin
        if (reset) begin
            written_q    <= '0;
            dout1_q      <= '0;
            dout_valid_q <= 1'b0;
            collision_q  <= 1'b0;
        end else begin
            written_q    <= written_d;
            dout1_q      <= dout1_d;
            dout_valid_q <= dout_valid_d;
            collision_q  <= collision_d;
        end
    end

    // Storage array is not reset; a request presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    assign dout1      = dout1_q;
    assign dout_valid = dout_valid_q;
    assign collision  = collision_q;

endmodule

// File: doc/two_write_one_read_reg_file.md
TWO_WRITE_ONE_READ_REG_FILE -- requirements
Module: two_write_one_read_reg_file

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter SHALL be: DATA_WIDTH, default 16, width of each storage entry and data port.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 din1  input  DATA_WIDTH  write data, port 1.
REQ-006 wad1  input  5  write address, port 1.
REQ-007 wen1  input  1  write enable, port 1.
REQ-008 din2  input  DATA_WIDTH  write data, port 2.
REQ-009 wad2  input  5  write address, port 2.
REQ-010 wen2  input  1  write enable, port 2.
REQ-011 rad1  input  5  read address.
REQ-012 ren1  input  1  read enable.
REQ-013 dout1  output  DATA_WIDTH  registered read data.
REQ-014 dout_valid  output  1  registered; high for the one cycle after a read that returned data.
REQ-015 collision  output  1  registered; high for the one cycle after a conflicting request.

Function
REQ-016 Storage SHALL be 32 entries of DATA_WIDTH bits, plus a 32-bit written bitmap with one bit per entry.
REQ-017 A raw conflict SHALL be any of: wen1 & wen2 & (wad1==wad2); wen1 & ren1 & (rad1==wad1); wen2 & ren1 & (rad1==wad2).
REQ-018 On a conflict edge, collision SHALL be set to 1; no storage write, no bitmap update and no dout1 update SHALL occur; dout_valid SHALL be 0.
REQ-019 On a non-conflict edge, collision SHALL be 0, and each enabled write port SHALL store its din at its address and set that address's written bit.
REQ-020 On a non-conflict edge, if both write ports are enabled, both writes SHALL complete in the same edge to their different addresses.
REQ-021 On a non-conflict edge with ren1=1 and written[rad1]=1, dout1 SHALL load the entry at rad1 and dout_valid SHALL be 1 (read latency is 1 cycle).
REQ-022 On a non-conflict edge with ren1=1 and written[rad1]=0, dout1 SHALL hold and dout_valid SHALL be 0.
REQ-023 On a non-conflict edge with ren1=0, dout1 SHALL hold and dout_valid SHALL be 0.
REQ-024 Rewriting an already-written address SHALL overwrite the entry; its written bit SHALL stay 1.
REQ-025 Address 0 and address 31 SHALL behave identically to all other addresses; there is no wrap-around or reserved entry.

Reset
REQ-026 While reset=1 at a rising edge, dout1 SHALL be 0, dout_valid SHALL be 0, collision SHALL be 0, and the written bitmap SHALL be all 0; reset SHALL override all enables.
REQ-027 Storage contents SHALL NOT be reset; after reset every entry SHALL be unreadable until it is rewritten.
REQ-028 A reset asserted while a request is presented SHALL discard that request; no write SHALL take effect in that cycle.

Configuration
REQ-029 Macro WRITE_FORWARD_EN SHALL control read-during-write forwarding.
REQ-030 When WRITE_FORWARD_EN is undefined, behaviour SHALL be exactly REQ-017 to REQ-025.
REQ-031 When WRITE_FORWARD_EN is defined, a read matching an enabled write address SHALL NOT be a conflict; only wen1 & wen2 & (wad1==wad2) SHALL be a conflict.
REQ-032 In that forwarding case, the write SHALL complete, dout1 SHALL load the matching port's din, and dout_valid SHALL be 1, regardless of the prior written bit.

Verification
REQ-033 Reset, then ren1=1, rad1=3 -> next cycle dout1=0, dout_valid=0, collision=0.
REQ-034 wen1=1, wad1=5, din1=0x1234 and wen2=1, wad2=9, din2=0xBEEF in one cycle; then ren1 of rad1=5, then of rad1=9 -> dout1=0x1234 then 0xBEEF, each with dout_valid=1.
REQ-035 wen1 and wen2 both to wad=7 (din1=0xAAAA, din2=0x5555) -> collision=1 next cycle, entry 7 unwritten; a later read of 7 gives dout_valid=0 with dout1 held.
REQ-036 Entry 31 holds 0x00FF; then wen2=1, wad2=31, din2=0x0F0F with ren1=1, rad1=31 -> without the macro: collision=1 and entry 31 unchanged (0x00FF); with WRITE_FORWARD_EN: dout1=0x0F0F, dout_valid=1, collision=0.
REQ-037 Entry 0 written with 0xCAFE; reset pulsed for 1 cycle; then read of rad1=0 -> dout_valid=0, dout1=0.
